fp_op_sched: RTL and testbench

FP_OP_SCHED -- requirements
Module: fp_op_sched

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_tag_fifo.sv | 52 +++++
 rtl/fp_op_sched.sv | 171 +++++++++++++++++
 tb/tb_fp_op_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared opcode constants and result-tag encoding for the FP op scheduler.
package fp_pkg;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_SINE = 3'b100;

    localparam int TAG_W = 2;

    typedef enum logic [TAG_W-1:0] {
        TAG_ADD  = 2'd0,
        TAG_MUL  = 2'd1,
        TAG_SINE = 2'd2,
        TAG_ILL  = 2'd3
    } tag_e;

    // Sine decodes as illegal when the sine unit is not built in.
    function automatic logic [TAG_W-1:0] op_to_tag(input logic [2:0] op, input logic sine_en);
        logic [TAG_W-1:0] t;
        case (op)
            OP_ADD:  t = TAG_ADD;
            OP_MUL:  t = TAG_MUL;
            OP_SINE: t = sine_en ? TAG_SINE : TAG_ILL;
            default: t = TAG_ILL;
        endcase
        return t;
    endfunction
endpackage

// File: rtl/fp_tag_fifo.sv
// In-order tag FIFO; records which unit owns each accepted op so results retire in issue order.
module fp_tag_fifo
    import fp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [TAG_W-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_cnt;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_cnt == CNT_FULL);
    assign empty  = (r_cnt == '0);
    assign head   = r_mem[r_rd];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= push_tag;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/fp_op_sched.sv
// Issues add/mul/sine ops to their units and retires results in issue order.
// Sine support is built only when FP_OPSCHED_SINE_EN is defined; otherwise opcode 100 is illegal.
module fp_op_sched
    import fp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        add_start,
    output logic        mul_start,
    output logic        sine_start,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        add_done,
    input  logic        mul_done,
    input  logic        sine_done,
    input  logic [31:0] add_result,
    input  logic [31:0] mul_result,
    input  logic [31:0] sine_result,
    input  logic        add_overflow,
    input  logic        mul_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        illegal,
    output logic        busy
);
    logic [2:0]       r_busy;
    logic [2:0]       r_hold_vld;
    logic [2:0]       r_hold_ovf;
    logic [31:0]      r_hold_res [3];
    logic [2:0]       r_start;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;

    logic [TAG_W-1:0] w_req_tag;
    logic [TAG_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_tgt_busy;
    logic             w_accept;
    logic             w_pop;
    logic             w_head_vld;
    logic             w_head_ill;
    logic             w_head_ovf;
    logic [31:0]      w_head_res;
    logic [2:0]       w_done;
    logic [2:0]       w_ovf_in;
    logic [31:0]      w_res_in [3];
    logic             w_sine_done;
    logic [31:0]      w_sine_res;

`ifdef FP_OPSCHED_SINE_EN
    localparam logic SINE_EN = 1'b1;
    assign w_sine_done = sine_done;
    assign w_sine_res  = sine_result;
    assign sine_start  = r_start[2];
`else
    localparam logic SINE_EN = 1'b0;
    logic w_unused_sine;
    assign w_sine_done   = 1'b0;
    assign w_sine_res    = 32'h0;
    assign sine_start    = 1'b0;
    assign w_unused_sine = ^{sine_done, sine_result, r_start[2]};
`endif

    assign w_done      = {w_sine_done, mul_done, add_done};
    assign w_ovf_in    = {1'b0, mul_overflow, add_overflow};
    assign w_res_in[0] = add_result;
    assign w_res_in[1] = mul_result;
    assign w_res_in[2] = w_sine_res;

    assign w_req_tag = op_to_tag(req_op, SINE_EN);

    always_comb begin
        w_tgt_busy = 1'b0;
        case (w_req_tag)
            TAG_ADD:  w_tgt_busy = r_busy[0];
            TAG_MUL:  w_tgt_busy = r_busy[1];
            TAG_SINE: w_tgt_busy = r_busy[2];
            default:  w_tgt_busy = 1'b0;
        endcase
    end

    assign req_ready = !rst && !w_full && !w_tgt_busy;
    assign w_accept  = req_valid && req_ready;

    fp_tag_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_accept),
        .push_tag (w_req_tag),
        .pop      (w_pop),
        .full     (w_full),
        .empty    (w_empty),
        .head     (w_head)
    );

    always_comb begin
        w_head_vld = 1'b1;
        w_head_res = 32'h0;
        w_head_ovf = 1'b0;
        w_head_ill = 1'b0;
        case (w_head)
            TAG_ADD:  begin w_head_vld = r_hold_vld[0]; w_head_res = r_hold_res[0]; w_head_ovf = r_hold_ovf[0]; end
            TAG_MUL:  begin w_head_vld = r_hold_vld[1]; w_head_res = r_hold_res[1]; w_head_ovf = r_hold_ovf[1]; end
            TAG_SINE: begin w_head_vld = r_hold_vld[2]; w_head_res = r_hold_res[2]; w_head_ovf = 1'b0; end
            default:  w_head_ill = 1'b1;
        endcase
    end

    // Outputs are gated by rst so they read zero during the reset cycle itself.
    assign out_valid = !rst && !w_empty && w_head_vld;
    assign w_pop     = out_valid && out_ready;
    assign result    = out_valid ? w_head_res : 32'h0;
    assign overflow  = out_valid && w_head_ovf;
    assign illegal   = out_valid && w_head_ill;
    assign busy      = !rst && !w_empty;

    assign add_start = r_start[0];
    assign mul_start = r_start[1];
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a  <= 32'h0;
            r_op_b  <= 32'h0;
            r_start <= 3'b0;
        end else begin
            for (int i = 0; i < 3; i++)
                r_start[i] <= w_accept && (w_req_tag == 2'(i));
            if (w_accept) begin
                r_op_a <= req_a;
                r_op_b <= req_b;
            end
        end
    end

    // A unit's hold only captures while it owns an op and the hold is empty; late or stray dones drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 3'b0;
            r_hold_vld <= 3'b0;
            r_hold_ovf <= 3'b0;
            for (int i = 0; i < 3; i++) r_hold_res[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_accept && (w_req_tag == 2'(i)))
                    r_busy[i] <= 1'b1;
                else if (w_pop && (w_head == 2'(i)))
                    r_busy[i] <= 1'b0;

                if (w_done[i] && r_busy[i] && !r_hold_vld[i]) begin
                    r_hold_vld[i] <= 1'b1;
                    r_hold_res[i] <= w_res_in[i];
                    r_hold_ovf[i] <= w_ovf_in[i];
                end else if (w_pop && (w_head == 2'(i))) begin
                    r_hold_vld[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_op_sched.sv
// Directed-vector bench for fp_op_sched; expectations follow the sine build macro.
module tb_fp_op_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        add_start, mul_start, sine_start;
    logic [31:0] op_a, op_b;
    logic        add_done, mul_done, sine_done;
    logic [31:0] add_result, mul_result, sine_result;
    logic        add_overflow, mul_overflow;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        overflow, illegal, busy;

    int n_vec = 0;
    int n_err = 0;
    logic sine_seen = 1'b0;

`ifdef FP_OPSCHED_SINE_EN
    localparam logic SINE_EXP = 1'b1;
`else
    localparam logic SINE_EXP = 1'b0;
`endif

    fp_op_sched #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .add_start(add_start), .mul_start(mul_start), .sine_start(sine_start), .op_a(op_a), .op_b(op_b),
        .add_done(add_done), .mul_done(mul_done), .sine_done(sine_done),
        .add_result(add_result), .mul_result(mul_result), .sine_result(sine_result),
        .add_overflow(add_overflow), .mul_overflow(mul_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sine_start === 1'b1) sine_seen = 1'b1;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle;
        req_valid = 0; req_op = 3'b000; req_a = 0; req_b = 0;
        add_done = 0; mul_done = 0; sine_done = 0;
        add_result = 0; mul_result = 0; sine_result = 0;
        add_overflow = 0; mul_overflow = 0; out_ready = 0;
    endtask

    task test_reset;
        idle(); rst = 1;
        tick(); tick();
        req_valid = 1; req_op = 3'b001;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", req_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_ovalid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (op_a !== 32'h0 || op_b !== 32'h0) begin n_err++; $display("FAIL rst_ops got %h/%h want 0/0", op_a, op_b); end
        n_vec++; if ({add_start, mul_start, sine_start} !== 3'b000) begin n_err++; $display("FAIL rst_start got %b want 000", {add_start, mul_start, sine_start}); end
        n_vec++; if (result !== 32'h0 || illegal !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL rst_out got %h/%b/%b want 0/0/0", result, overflow, illegal); end
        tick();
        rst = 0; req_valid = 0;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
    endtask

    task test_single_add;
        tick();
        req_valid = 1; req_op = 3'b001; req_a = 32'h3F800000; req_b = 32'h40000000;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL add_ready got %b want 1", req_ready); end
        tick(); req_valid = 0;
        @(negedge clk);
        n_vec++; if (add_start !== 1'b1 || mul_start !== 1'b0) begin n_err++; $display("FAIL add_start got %b/%b want 1/0", add_start, mul_start); end
        n_vec++; if (op_a !== 32'h3F800000 || op_b !== 32'h40000000) begin n_err++; $display("FAIL add_ops got %h/%h want 3f800000/40000000", op_a, op_b); end
        tick();
        @(negedge clk);
        n_vec++; if (add_start !== 1'b0) begin n_err++; $display("FAIL add_start_one got %b want 0", add_start); end
        tick(); add_done = 1; add_result = 32'h40400000;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_early got %b want 0", out_valid); end
        tick(); add_done = 0; out_ready = 1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_ovalid got %b want 1", out_valid); end
        n_vec++; if (result !== 32'h40400000 || overflow !== 1'b0 || illegal !== 1'b0) begin n_err++; $display("FAIL add_result got %h/%b/%b want 40400000/0/0", result, overflow, illegal); end
        tick(); out_ready = 0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL add_drain got %b/%b want 0/0", out_valid, busy); end
    endtask

    task test_out_of_order;
        tick(); req_valid = 1; req_op = 3'b010; req_a = 32'h40000000; req_b = 32'h40400000;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ooo_mul_ready got %b want 1", req_ready); end
        tick(); req_op = 3'b001; req_a = 32'h40000000; req_b = 32'h40400000;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1 || mul_start !== 1'b1) begin n_err++; $display("FAIL ooo_add_ready got %b/%b want 1/1", req_ready, mul_start); end
        tick(); req_valid = 0; add_done = 1; add_result = 32'h40A00000;
        @(negedge clk);
        n_vec++; if (add_start !== 1'b1) begin n_err++; $display("FAIL ooo_add_start got %b want 1", add_start); end
        tick(); add_done = 0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL ooo_blocked got %b/%b want 0/1", out_valid, busy); end
        tick(); mul_done = 1; mul_result = 32'h40C00000; mul_overflow = 1;
        tick(); mul_done = 0; mul_overflow = 0; out_ready = 1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || result !== 32'h40C00000 || overflow !== 1'b1) begin n_err++; $display("FAIL ooo_first got %b/%h/%b want 1/40c00000/1", out_valid, result, overflow); end
        tick();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || result !== 32'h40A00000 || overflow !== 1'b0) begin n_err++; $display("FAIL ooo_second got %b/%h/%b want 1/40a00000/0", out_valid, result, overflow); end
        tick(); out_ready = 0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ooo_idle got %b want 0", busy); end
    endtask

    task test_backpressure;
        logic [2:0] ops [4];
        ops[0] = 3'b010; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b011;
        for (int i = 0; i < 4; i++) begin
            tick(); req_valid = 1; req_op = ops[i]; req_a = 32'(i); req_b = 32'(i + 8);
            @(negedge clk);
            n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_fill%0d got %b want 1", i, req_ready); end
        end
        tick(); req_op = 3'b000;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got %b want 0", req_ready); end
        tick(); req_valid = 0;
        mul_done = 1; mul_result = 32'h11111111;
        add_done = 1; add_result = 32'h22222222; add_overflow = 1;
        sine_done = 1; sine_result = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            tick();
            mul_done = 0; sine_done = 0; add_overflow = 0;
            add_done = (i == 0); add_result = 32'hDEADBEEF;
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1 || result !== 32'h11111111 || overflow !== 1'b0 || illegal !== 1'b0)
                begin n_err++; $display("FAIL bp_hold%0d got %b/%h/%b/%b want 1/11111111/0/0", i, out_valid, result, overflow, illegal); end
        end
        tick(); add_done = 0; out_ready = 1;
        @(negedge clk);
        n_vec++; if (result !== 32'h11111111) begin n_err++; $display("FAIL bp_pop_mul got %h want 11111111", result); end
        tick();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || result !== 32'h22222222 || overflow !== 1'b1 || illegal !== 1'b0)
            begin n_err++; $display("FAIL bp_pop_add got %b/%h/%b/%b want 1/22222222/1/0", out_valid, result, overflow, illegal); end
        tick();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || result !== (SINE_EXP ? 32'h33333333 : 32'h0) || overflow !== 1'b0 || illegal !== !SINE_EXP)
            begin n_err++; $display("FAIL bp_pop_sine got %b/%h/%b/%b want 1/%h/0/%b", out_valid, result, overflow, illegal, SINE_EXP ? 32'h33333333 : 32'h0, !SINE_EXP); end
        tick();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || result !== 32'h0 || overflow !== 1'b0 || illegal !== 1'b1)
            begin n_err++; $display("FAIL bp_pop_ill got %b/%h/%b/%b want 1/0/0/1", out_valid, result, overflow, illegal); end
        tick(); out_ready = 0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b/%b want 0/0", out_valid, busy); end
        n_vec++; if (sine_seen !== SINE_EXP) begin n_err++; $display("FAIL sine_start_seen got %b want %b", sine_seen, SINE_EXP); end
    endtask

    task test_unit_conflict;
        tick(); req_valid = 1; req_op = 3'b001; req_a = 32'hA1; req_b = 32'hB1;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL cf_first got %b want 1", req_ready); end
        tick(); req_a = 32'hA2; req_b = 32'hB2;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL cf_blocked got %b want 0", req_ready); end
        tick(); add_done = 1; add_result = 32'h0A;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL cf_done got %b want 0", req_ready); end
        tick(); add_done = 0; out_ready = 1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || result !== 32'h0A || req_ready !== 1'b0)
            begin n_err++; $display("FAIL cf_pop got %b/%h/%b want 1/0000000a/0", out_valid, result, req_ready); end
        tick(); out_ready = 0;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL cf_freed got %b want 1", req_ready); end
        tick(); req_valid = 0;
        @(negedge clk);
        n_vec++; if (add_start !== 1'b1 || op_a !== 32'hA2 || op_b !== 32'hB2)
            begin n_err++; $display("FAIL cf_reissue got %b/%h/%h want 1/a2/b2", add_start, op_a, op_b); end
        tick(); add_done = 1; add_result = 32'h0B;
        tick(); add_done = 0; out_ready = 1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || result !== 32'h0B) begin n_err++; $display("FAIL cf_second got %b/%h want 1/0000000b", out_valid, result); end
        tick(); out_ready = 0;
    endtask

    task test_reset_mid;
        tick(); req_valid = 1; req_op = 3'b001; req_a = 32'h5; req_b = 32'h6;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rm_accept got %b want 1", req_ready); end
        tick(); req_valid = 0; rst = 1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b0)
            begin n_err++; $display("FAIL rm_in_rst got %b/%b/%b want 0/0/0", busy, out_valid, req_ready); end
        tick(); rst = 0;
        @(negedge clk);
        n_vec++; if (add_start !== 1'b0) begin n_err++; $display("FAIL rm_start got %b want 0", add_start); end
        tick(); add_done = 1; add_result = 32'h77;
        tick(); add_done = 0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
            begin n_err++; $display("FAIL rm_late_done got %b/%b/%b want 0/0/1", out_valid, busy, req_ready); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_out_of_order();
        test_backpressure();
        test_unit_conflict();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
